schoolbook_serial: RTL and testbench

Parametrised digit-serial schoolbook multiplier with a start/done handshake. It computes the unsigned product `c = a × b` by consuming `b` one DW-bit digit per cycle and accumulating shifted partial products of `a`. It is the successor of the free-running bit-serial schoolbook core: widths and digit size are generic, operands are latched on request, and results are held until the next completion. It sits in the library's large-integer multiplier family, where it is the area-optimised option.

---
 rtl/tt_mul_pkg.sv | 13 +
 rtl/schoolbook_serial_digit_pp.sv | 11 +
 rtl/schoolbook_serial.sv | 69 ++++++
 tb/tb_schoolbook_serial.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/tt_mul_pkg.sv
// tt_mul_pkg: shared constants helpers and FSM state type for the serial multiplier family
package tt_mul_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic int ceil_div(int x, int y);
    return (x + y - 1) / y;
  endfunction
  function automatic int clog2(int x);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(x)) r++;
    return r;
  endfunction
endpackage

// File: rtl/schoolbook_serial_digit_pp.sv
// sb_digit_pp: combinational multiplicand-by-digit partial product, swappable for a DSP or Karatsuba digit
module sb_digit_pp #(
  parameter int AW = 521,
  parameter int DW = 8
) (
  input  logic [AW-1:0]    i_ra,
  input  logic [DW-1:0]    i_digit,
  output logic [AW+DW-1:0] o_pp
);
  assign o_pp = (AW+DW)'(i_ra) * (AW+DW)'(i_digit);
endmodule

// File: rtl/schoolbook_serial.sv
// schoolbook_serial: digit-serial schoolbook multiplier with start/done handshake
module schoolbook_serial
  import tt_mul_pkg::*;
#(
  parameter int AW = 521,
  parameter int BW = 521,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [AW-1:0] i_a,
  input  logic [BW-1:0] i_b,
  output logic          o_busy,
  output logic          o_done,
  output logic [AW+BW-1:0] o_c
);
  localparam int ND = ceil_div(BW, DW);
  localparam int CW = clog2(ND + 1);
  localparam int PW = ND * DW;
  localparam int OW = AW + BW;
  state_t r_state, w_state_nx;
  logic [AW-1:0] r_ra;
  logic [PW-1:0] r_rb;
  logic [OW-1:0] r_acc, r_c, w_sh, w_sum;
  logic [CW-1:0] r_cnt;
  logic r_done, w_last;
  logic [AW+DW-1:0] w_pp;
  sb_digit_pp #(.AW(AW), .DW(DW)) u_pp (
    .i_ra(r_ra),
    .i_digit(r_rb[DW-1:0]),
    .o_pp(w_pp)
  );
  assign w_last = r_cnt == CW'(ND - 1);
  assign w_sh = OW'(w_pp) << (int'(r_cnt) * DW);
  assign w_sum = r_acc + w_sh;
  assign o_busy = r_state == RUN;
  assign o_done = r_done;
  assign o_c = r_c;
  always_ff @(posedge clk)
    if (!rst) r_state <= IDLE;
    else r_state <= w_state_nx;
  always_comb begin
    w_state_nx = r_state;
    w_state_nx = r_state == IDLE ? (i_start ? RUN : IDLE) : (w_last ? IDLE : RUN);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_done <= 1'b0;
      r_c <= '0;
      r_cnt <= '0;
    end else begin
      r_done <= r_state == RUN && w_last;
      if (r_state == IDLE) begin
        if (i_start) begin
          r_ra <= i_a;
          r_rb <= PW'(i_b);
          r_acc <= '0;
          r_cnt <= '0;
        end
      end else begin
        r_acc <= w_sum;
        r_rb <= r_rb >> DW;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) r_c <= w_sum;
      end
    end
  end
endmodule

// File: tb/tb_schoolbook_serial.sv
// tb_schoolbook_serial: directed and randomized checks of schoolbook_serial against an arithmetic product model
module tb_schoolbook_serial;
  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;
  logic st0 = 0, st1 = 0, st2 = 0, st3 = 0, st4 = 0;
  logic bz0, bz1, bz2, bz3, bz4, dn0, dn1, dn2, dn3, dn4;
  logic [520:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [16:0] a2 = '0;
  logic [12:0] b2 = '0;
  logic [63:0] a3 = '0, b3 = '0;
  logic [32:0] a4 = '0;
  logic [6:0] b4 = '0;
  logic [1041:0] c0, c1;
  logic [29:0] c2;
  logic [127:0] c3;
  logic [39:0] c4;
  int aws[5] = '{521, 521, 17, 64, 33};
  int bws[5] = '{521, 521, 13, 64, 7};
  int dws[5] = '{8, 1, 4, 64, 3};
  int n_pass = 0, n_tot = 0, n_fail = 0;

  schoolbook_serial u0 (.clk(clk), .rst(rst), .i_start(st0), .i_a(a0), .i_b(b0),
    .o_busy(bz0), .o_done(dn0), .o_c(c0));
  schoolbook_serial #(.AW(521), .BW(521), .DW(1)) u1 (.clk(clk), .rst(rst), .i_start(st1),
    .i_a(a1), .i_b(b1), .o_busy(bz1), .o_done(dn1), .o_c(c1));
  schoolbook_serial #(.AW(17), .BW(13), .DW(4)) u2 (.clk(clk), .rst(rst), .i_start(st2),
    .i_a(a2), .i_b(b2), .o_busy(bz2), .o_done(dn2), .o_c(c2));
  schoolbook_serial #(.AW(64), .BW(64), .DW(64)) u3 (.clk(clk), .rst(rst), .i_start(st3),
    .i_a(a3), .i_b(b3), .o_busy(bz3), .o_done(dn3), .o_c(c3));
  schoolbook_serial #(.AW(33), .BW(7), .DW(3)) u4 (.clk(clk), .rst(rst), .i_start(st4),
    .i_a(a4), .i_b(b4), .o_busy(bz4), .o_done(dn4), .o_c(c4));

  task automatic chk(string tag, logic [1041:0] obs, logic [1041:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs[255:0], exp[255:0]);
    end
  endtask

  function automatic int nd_of(int k);
    return (bws[k] + dws[k] - 1) / dws[k];
  endfunction

  function automatic logic [1041:0] ref_prod(int k, logic [520:0] a, logic [520:0] b);
    logic [520:0] ma, mb;
    logic [1041:0] x, y;
    ma = '1;
    mb = '1;
    ma = ma >> (521 - aws[k]);
    mb = mb >> (521 - bws[k]);
    x = {521'b0, a & ma};
    y = {521'b0, b & mb};
    return x * y;
  endfunction

  function automatic logic [520:0] rnd();
    logic [520:0] r;
    r = '0;
    for (int i = 0; i < 17; i++) r = {r[488:0], 32'($urandom)};
    return r;
  endfunction

  task automatic drive(int k, logic s, logic [520:0] a, logic [520:0] b);
    case (k)
      0: begin st0 = s; a0 = a; b0 = b; end
      1: begin st1 = s; a1 = a; b1 = b; end
      2: begin st2 = s; a2 = a[16:0]; b2 = b[12:0]; end
      3: begin st3 = s; a3 = a[63:0]; b3 = b[63:0]; end
      default: begin st4 = s; a4 = a[32:0]; b4 = b[6:0]; end
    endcase
  endtask

  function automatic logic [1041:0] get_c(int k);
    case (k)
      0: return c0;
      1: return c1;
      2: return {1012'b0, c2};
      3: return {914'b0, c3};
      default: return {1002'b0, c4};
    endcase
  endfunction

  function automatic logic get_busy(int k);
    case (k)
      0: return bz0;
      1: return bz1;
      2: return bz2;
      3: return bz3;
      default: return bz4;
    endcase
  endfunction

  function automatic logic get_done(int k);
    case (k)
      0: return dn0;
      1: return dn1;
      2: return dn2;
      3: return dn3;
      default: return dn4;
    endcase
  endfunction

  task automatic start_op(int k, logic [520:0] a, logic [520:0] b, logic hold);
    drive(k, 1'b1, a, b);
    @(posedge clk);
    #1;
    chk("busy_at_accept", get_busy(k), 1);
    if (!hold) drive(k, 1'b0, rnd(), rnd());
  endtask

  task automatic finish_op(int k, logic [1041:0] exp, logic hold, int n0);
    int n;
    logic ok;
    ok = 1'b1;
    for (n = n0 + 1; n <= nd_of(k) + 10; n++) begin
      @(posedge clk);
      #1;
      if (get_done(k)) break;
      if (!get_busy(k)) ok = 1'b0;
    end
    chk("latency", n, nd_of(k));
    chk("product", get_c(k), exp);
    chk("busy_at_done", get_busy(k), 0);
    chk("busy_during_run", ok, 1);
    @(posedge clk);
    #1;
    chk("done_one_cycle", get_done(k), 0);
    chk("busy_after_done", get_busy(k), hold);
  endtask

  initial begin
    logic [520:0] x, y, ones;
    logic ok;
    ones = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_c", c0, 0);
    chk("reset_busy", bz0, 0);
    chk("reset_done", dn0, 0);
    rst = 1;
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("idle_c", c0, 0);
      chk("idle_busy_done", {bz0, dn0}, 0);
    end
    start_op(0, ones, ones, 1'b0);
    finish_op(0, ref_prod(0, ones, ones), 1'b0, 0);
    y = rnd();
    start_op(0, '0, y, 1'b0);
    finish_op(0, 0, 1'b0, 0);
    x = rnd();
    start_op(0, x, 521'd1, 1'b0);
    finish_op(0, {521'b0, x}, 1'b0, 0);
    x = rnd();
    y = rnd();
    start_op(0, x, y, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    drive(0, 1'b1, rnd(), rnd());
    @(posedge clk);
    #1;
    drive(0, 1'b0, rnd(), rnd());
    finish_op(0, ref_prod(0, x, y), 1'b0, 4);
    x = rnd();
    y = rnd();
    start_op(0, x, y, 1'b1);
    finish_op(0, ref_prod(0, x, y), 1'b1, 0);
    drive(0, 1'b0, x, y);
    finish_op(0, ref_prod(0, x, y), 1'b0, 0);
    x = rnd();
    y = rnd();
    start_op(0, x, y, 1'b0);
    ok = 1'b1;
    repeat (29) begin
      @(posedge clk);
      #1;
      if (dn0) ok = 1'b0;
    end
    rst = 0;
    @(posedge clk);
    #1;
    chk("midrst_busy", bz0, 0);
    chk("midrst_c", c0, 0);
    chk("midrst_done", dn0, 0);
    rst = 1;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (dn0 || bz0) ok = 1'b0;
    end
    chk("midrst_no_done", ok, 1);
    x = rnd();
    y = rnd();
    start_op(0, x, y, 1'b0);
    finish_op(0, ref_prod(0, x, y), 1'b0, 0);
    for (int k = 1; k < 5; k++) begin
      for (int i = 0; i < (k == 1 ? 20 : 200); i++) begin
        x = i == 0 ? ones : rnd();
        y = i == 0 ? ones : rnd();
        start_op(k, x, y, 1'b0);
        finish_op(k, ref_prod(k, x, y), 1'b0, 0);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
